// File: rtl/bsg_fifo_1r1w_sync_prefetch.sv
// Ready/valid FIFO built on a 1-cycle-latency synchronous 1R1W memory.
// A 2-entry prefetch buffer hides the read latency, so the head is visible with v_o.

module bsg_mem_1r1w_sync #(
  parameter int width_p = 64,
  parameter int els_p = 50,
  parameter int read_write_same_addr_p = 0,
  parameter int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic                     r_v_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);
  logic [width_p-1:0] mem_reg [els_p];

  // Array write kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (w_v_i) mem_reg[w_addr_i] <= w_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) r_data_o <= '0;
    else if (r_v_i) r_data_o <= mem_reg[r_addr_i];
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && w_v_i && r_v_i && read_write_same_addr_p == 0)
      assert (w_addr_i != r_addr_i);
  end
endmodule

module bsg_fifo_1r1w_sync_prefetch #(
  parameter int width_p = 64,
  parameter int els_p = 50,
  parameter int cap_lp = els_p + 2,
  parameter int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
  parameter int count_width_lp = $clog2(cap_lp + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      v_i,
  input  logic [width_p-1:0]        data_i,
  output logic                      ready_o,
  output logic                      v_o,
  output logic [width_p-1:0]        data_o,
  input  logic                      yumi_i,
  output logic [count_width_lp-1:0] count_o
);
  localparam int mem_count_width_lp = $clog2(els_p + 1);
  localparam logic [mem_count_width_lp-1:0] mem_full_lp = mem_count_width_lp'(els_p);
  localparam logic [ptr_width_lp-1:0] ptr_last_lp = ptr_width_lp'(els_p - 1);

  logic [ptr_width_lp-1:0]       rptr_reg, rptr_next, wptr_reg, wptr_next;
  logic [mem_count_width_lp-1:0] mem_count_reg, mem_count_next;
  logic                          inflight_reg;
  logic [1:0]                    buf_count_reg, buf_count_next, buf_after_yumi;
  logic [width_p-1:0]            buf_reg [2];
  logic [width_p-1:0]            buf_next [2];
  logic [2:0]                    pending_after_yumi;
  logic                          enq, bypass, mem_w, rd_issue, push;
  logic [width_p-1:0]            push_data, r_data;

  assign ready_o = ~reset_i & (mem_count_reg != mem_full_lp);
  assign v_o     = (buf_count_reg != 2'd0);
  assign data_o  = buf_reg[0];
  assign count_o = count_width_lp'(mem_count_reg) + count_width_lp'(inflight_reg)
                 + count_width_lp'(buf_count_reg);

  assign enq                = v_i & ready_o;
  assign buf_after_yumi     = buf_count_reg - {1'b0, yumi_i};
  assign pending_after_yumi = {1'b0, buf_count_reg} + {2'b00, inflight_reg} - {2'b00, yumi_i};
  // Bypass only when nothing older sits in memory or in flight, preserving order.
  assign bypass   = enq & (mem_count_reg == '0) & ~inflight_reg & (buf_after_yumi < 2'd2);
  assign mem_w    = enq & ~bypass;
  assign rd_issue = (mem_count_reg != '0) & (pending_after_yumi < 3'd2);
  assign push     = bypass | inflight_reg;
  assign push_data = inflight_reg ? r_data : data_i;

  bsg_mem_1r1w_sync #(
    .width_p(width_p),
    .els_p(els_p),
    .read_write_same_addr_p(0),
    .addr_width_lp(ptr_width_lp)
  ) mem (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .w_v_i(mem_w),
    .w_addr_i(wptr_reg),
    .w_data_i(data_i),
    .r_v_i(rd_issue),
    .r_addr_i(rptr_reg),
    .r_data_o(r_data)
  );

  always_comb begin
    wptr_next = wptr_reg;
    rptr_next = rptr_reg;
    mem_count_next = mem_count_reg;
    if (mem_w) wptr_next = (wptr_reg == ptr_last_lp) ? '0 : wptr_reg + 1'b1;
    if (rd_issue) rptr_next = (rptr_reg == ptr_last_lp) ? '0 : rptr_reg + 1'b1;
    if (mem_w && !rd_issue) mem_count_next = mem_count_reg + 1'b1;
    else if (!mem_w && rd_issue) mem_count_next = mem_count_reg - 1'b1;
  end

  // Pop shifts first; the push then lands at the first free slot.
  always_comb begin
    buf_next[0] = buf_reg[0];
    buf_next[1] = buf_reg[1];
    buf_count_next = buf_count_reg;
    if (yumi_i) begin
      buf_next[0] = buf_reg[1];
      buf_count_next = buf_count_next - 2'd1;
    end
    if (push) begin
      buf_next[buf_count_next[0]] = push_data;
      buf_count_next = buf_count_next + 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr_reg      <= '0;
      wptr_reg      <= '0;
      mem_count_reg <= '0;
      inflight_reg  <= 1'b0;
      buf_count_reg <= 2'd0;
      for (int i = 0; i < 2; i++) buf_reg[i] <= '0;
    end else begin
      rptr_reg      <= rptr_next;
      wptr_reg      <= wptr_next;
      mem_count_reg <= mem_count_next;
      inflight_reg  <= rd_issue;
      buf_count_reg <= buf_count_next;
      for (int i = 0; i < 2; i++) buf_reg[i] <= buf_next[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) assert (!(yumi_i && !v_o));
  end
endmodule

// File: tb/tb_bsg_fifo_1r1w_sync_prefetch.sv
// Scoreboard bench for the prefetch FIFO: order, occupancy, latency, fill and reset behaviour.
module tb_bsg_fifo_1r1w_sync_prefetch;
  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        v_i = 1'b0;
  logic [63:0] data_i = '0;
  logic        ready_o, v_o, yumi_i = 1'b0;
  logic [63:0] data_o;
  logic [5:0]  count_o;

  int tests_run = 0;
  int tests_failed = 0;
  logic [63:0] sb [$];

  bsg_fifo_1r1w_sync_prefetch #(.width_p(64), .els_p(50)) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
    .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i), .count_o(count_o)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // One clock of stimulus; inputs applied after a negedge, model updated at the posedge.
  task automatic step(input logic v, input logic [63:0] d, input logic y);
    logic enq;
    v_i = v; data_i = d; yumi_i = y;
    enq = v && ready_o;
    @(posedge clk);
    if (enq) begin
      sb.push_back(d);
      $display("[TB] enq 0x%0h", d);
    end
    if (y && sb.size() > 0) begin
      $display("[TB] deq 0x%0h", sb[0]);
      void'(sb.pop_front());
    end
    @(negedge clk);
    v_i = 1'b0; data_i = '0; yumi_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests_run++; if (ready_o !== 1'b0) begin tests_failed++; $display("FAIL reset_ready_hi: got %0b want 0", ready_o); end
    tests_run++; if (v_o !== 1'b0) begin tests_failed++; $display("FAIL reset_v_o: got %0b want 0", v_o); end
    tests_run++; if (count_o !== 6'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", count_o); end
    reset_i = 1'b0;
    #1;
    tests_run++; if (ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset_ready_lo: got %0b want 1", ready_o); end
    tests_run++; if (data_o !== 64'd0) begin tests_failed++; $display("FAIL reset_data: got 0x%0h want 0", data_o); end
  endtask

  task automatic test_single();
    step(1'b1, 64'hA5, 1'b0);
    tests_run++; if (v_o !== 1'b1) begin tests_failed++; $display("FAIL single_v_o: got %0b want 1", v_o); end
    tests_run++; if (data_o !== 64'hA5) begin tests_failed++; $display("FAIL single_data: got 0x%0h want 0xa5", data_o); end
    tests_run++; if (count_o !== 6'd1) begin tests_failed++; $display("FAIL single_count1: got %0d want 1", count_o); end
    step(1'b0, 64'h0, v_o);
    tests_run++; if (count_o !== 6'd0) begin tests_failed++; $display("FAIL single_count0: got %0d want 0", count_o); end
    tests_run++; if (v_o !== 1'b0) begin tests_failed++; $display("FAIL single_empty: got %0b want 0", v_o); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 52; i++) begin
      tests_run++; if (ready_o !== 1'b1) begin tests_failed++; $display("FAIL fill_ready[%0d]: got %0b want 1", i, ready_o); end
      step(1'b1, 64'(i), 1'b0);
    end
    tests_run++; if (ready_o !== 1'b0) begin tests_failed++; $display("FAIL fill_full: got ready %0b want 0", ready_o); end
    tests_run++; if (count_o !== 6'd52) begin tests_failed++; $display("FAIL fill_count: got %0d want 52", count_o); end
    step(1'b1, 64'd99, 1'b0);
    tests_run++; if (count_o !== 6'd52) begin tests_failed++; $display("FAIL fill_ignored: got %0d want 52", count_o); end
    for (int i = 0; i < 52; i++) begin
      tests_run++; if (v_o !== 1'b1 || data_o !== 64'(i)) begin tests_failed++; $display("FAIL drain[%0d]: got v=%0b data=0x%0h want v=1 data=0x%0h", i, v_o, data_o, i); end
      step(1'b0, 64'h0, v_o);
    end
    tests_run++; if (count_o !== 6'd0 || v_o !== 1'b0) begin tests_failed++; $display("FAIL drain_empty: got count=%0d v=%0b want 0 0", count_o, v_o); end
  endtask

  task automatic test_wrap_stress();
    logic y;
    for (int i = 0; i < 200; i++) begin
      y = ($urandom_range(1, 0) == 1) && v_o;
      if (y) begin
        tests_run++; if (sb.size() == 0 || data_o !== sb[0]) begin tests_failed++; $display("FAIL stress_data[%0d]: got 0x%0h want 0x%0h", i, data_o, (sb.size() > 0) ? sb[0] : 64'hx); end
      end
      step($urandom_range(1, 0) == 1, {$urandom, $urandom}, y);
      tests_run++; if (count_o !== 6'(sb.size())) begin tests_failed++; $display("FAIL stress_count[%0d]: got %0d want %0d", i, count_o, sb.size()); end
    end
    for (int i = 0; i < 200 && sb.size() > 0; i++) begin
      if (v_o) begin
        tests_run++; if (data_o !== sb[0]) begin tests_failed++; $display("FAIL stress_drain: got 0x%0h want 0x%0h", data_o, sb[0]); end
      end
      step(1'b0, 64'h0, v_o);
    end
    tests_run++; if (sb.size() != 0 || count_o !== 6'd0) begin tests_failed++; $display("FAIL stress_empty: got left=%0d count=%0d want 0 0", sb.size(), count_o); end
  endtask

  task automatic test_rw_order();
    step(1'b1, 64'h01, 1'b0);
    step(1'b1, 64'h02, 1'b0);
    step(1'b1, 64'h03, 1'b0);
    tests_run++; if (count_o !== 6'd3) begin tests_failed++; $display("FAIL rw_count: got %0d want 3", count_o); end
    tests_run++; if (data_o !== 64'h01) begin tests_failed++; $display("FAIL rw_head: got 0x%0h want 0x1", data_o); end
    step(1'b1, 64'h11, 1'b1);
    tests_run++; if (count_o !== 6'd3) begin tests_failed++; $display("FAIL rw_count2: got %0d want 3", count_o); end
    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      if (v_o) begin
        tests_run++; if (data_o !== sb[0]) begin tests_failed++; $display("FAIL rw_order: got 0x%0h want 0x%0h", data_o, sb[0]); end
      end
      step(1'b0, 64'h0, v_o);
    end
    tests_run++; if (sb.size() != 0) begin tests_failed++; $display("FAIL rw_drain: got left=%0d want 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) step(1'b1, 64'h100 + 64'(i), 1'b0);
    repeat (3) step(1'b0, 64'h0, 1'b0);
    tests_run++; if (count_o !== 6'd5) begin tests_failed++; $display("FAIL b2b_count_start: got %0d want 5", count_o); end
    for (int i = 0; i < 20; i++) begin
      tests_run++; if (v_o !== 1'b1 || data_o !== sb[0]) begin tests_failed++; $display("FAIL b2b_data[%0d]: got v=%0b data=0x%0h want v=1 data=0x%0h", i, v_o, data_o, sb[0]); end
      step(1'b1, 64'h200 + 64'(i), 1'b1);
      tests_run++; if (count_o !== 6'd5) begin tests_failed++; $display("FAIL b2b_count[%0d]: got %0d want 5", i, count_o); end
    end
    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      if (v_o) begin
        tests_run++; if (data_o !== sb[0]) begin tests_failed++; $display("FAIL b2b_drain: got 0x%0h want 0x%0h", data_o, sb[0]); end
      end
      step(1'b0, 64'h0, v_o);
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 10; i++) step(1'b1, 64'h300 + 64'(i), 1'b0);
    step(1'b0, 64'h0, 1'b1);
    tests_run++; if (count_o !== 6'd9) begin tests_failed++; $display("FAIL mid_count: got %0d want 9", count_o); end
    reset_i = 1'b1;
    #1;
    tests_run++; if (ready_o !== 1'b0) begin tests_failed++; $display("FAIL mid_ready_hi: got %0b want 0", ready_o); end
    @(posedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    sb.delete();
    #1;
    tests_run++; if (v_o !== 1'b0 || count_o !== 6'd0 || ready_o !== 1'b1) begin tests_failed++; $display("FAIL mid_after: got v=%0b count=%0d ready=%0b want 0 0 1", v_o, count_o, ready_o); end
    step(1'b0, 64'h0, 1'b0);
    tests_run++; if (v_o !== 1'b0 || count_o !== 6'd0) begin tests_failed++; $display("FAIL mid_stale: got v=%0b count=%0d want 0 0", v_o, count_o); end
    step(1'b1, 64'h77, 1'b0);
    tests_run++; if (v_o !== 1'b1 || data_o !== 64'h77) begin tests_failed++; $display("FAIL mid_fresh: got v=%0b data=0x%0h want 1 0x77", v_o, data_o); end
    step(1'b0, 64'h0, v_o);
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_wrap_stress();
    test_rw_order();
    test_back_to_back();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
